// File: rtl/uart_rx_if.sv
// Signal bundle between the UART receiver and the host-side logic.
// The serial line and the consumer's clear strobe flow into the receiver;
// the received byte and its status flags flow back to the host.
interface uart_rx_if;
    logic       rx;
    logic       clear;
    logic [7:0] data;
    logic       busy;
    logic       error;
    logic       new_value;

    // Host side: drives the line and the clear strobe, observes the results.
    modport master (
        output rx,
        output clear,
        input  data,
        input  busy,
        input  error,
        input  new_value
    );

    // Receiver side.
    modport slave (
        input  rx,
        input  clear,
        output data,
        output busy,
        output error,
        output new_value
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// The line is synchronized through two flops and then sampled at the middle
// of each bit. The received byte is presented with sticky new_value and
// framing-error flags that the consumer clears. The receiver re-arms at the
// middle of the stop bit, so a back-to-back start edge is not missed.
module uart_rx #(
    parameter int CLOCK_FREQUENCY = 12000000,
    parameter int BAUD_RATE       = 9600
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave bus
);
    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = $clog2(CLKS_PER_BIT);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [1:0]    sync_r;
    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [2:0]    index_r;
    logic [7:0]    shift_r;
    logic [7:0]    data_r;
    logic          busy_r;
    logic          error_r;
    logic          new_value_r;

    logic          rxs_s;
    state_t        state_nxt_s;
    logic [TW-1:0] timer_nxt_s;
    logic [2:0]    index_nxt_s;
    logic [7:0]    shift_nxt_s;
    logic [7:0]    data_nxt_s;
    logic          busy_nxt_s;
    logic          err_set_s;
    logic          nv_set_s;

    assign rxs_s = sync_r[1];

    // Two-flop synchronizer for the asynchronous serial line; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], bus.rx};
        end
    end

    // Frame sequencing: next state, bit timer, bit index, shift register and flag set events.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        index_nxt_s = index_r;
        shift_nxt_s = shift_r;
        data_nxt_s  = data_r;
        busy_nxt_s  = busy_r;
        err_set_s   = 1'b0;
        nv_set_s    = 1'b0;
        case (state_r)
            IDLE: begin
                timer_nxt_s = '0;
                if (!rxs_s) begin
                    state_nxt_s = START;
                    busy_nxt_s  = 1'b1;
                end else begin
                    busy_nxt_s  = 1'b0;
                end
            end
            START: begin
                if (timer_r == HALF_LAST) begin
                    timer_nxt_s = '0;
                    if (!rxs_s) begin
                        state_nxt_s = DATA;
                        index_nxt_s = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: spurious edge.
                        state_nxt_s = IDLE;
                        busy_nxt_s  = 1'b0;
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            DATA: begin
                if (timer_r == BIT_LAST) begin
                    timer_nxt_s          = '0;
                    shift_nxt_s[index_r] = rxs_s;
                    if (index_r == 3'd7) begin
                        state_nxt_s = STOP;
                    end else begin
                        index_nxt_s = index_r + 3'd1;
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            STOP: begin
                if (timer_r == BIT_LAST) begin
                    // Leave at mid stop bit so an immediately following start edge is caught.
                    timer_nxt_s = '0;
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                    if (rxs_s) begin
                        data_nxt_s = shift_r;
                        nv_set_s   = 1'b1;
                    end else begin
                        err_set_s  = 1'b1;
                    end
                end else begin
                    timer_nxt_s = timer_r + TW'(1);
                end
            end
            default: begin
                state_nxt_s = IDLE;
                timer_nxt_s = '0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State register and receive datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            timer_r <= '0;
            index_r <= 3'd0;
            shift_r <= 8'h00;
            data_r  <= 8'h00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            index_r <= index_nxt_s;
            shift_r <= shift_nxt_s;
            data_r  <= data_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    // Sticky status flags: a set event in the same cycle as clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_value_r <= 1'b0;
            error_r     <= 1'b0;
        end else begin
            if (nv_set_s) begin
                new_value_r <= 1'b1;
            end else if (bus.clear) begin
                new_value_r <= 1'b0;
            end else begin
                new_value_r <= new_value_r;
            end
            if (err_set_s) begin
                error_r <= 1'b1;
            end else if (bus.clear) begin
                error_r <= 1'b0;
            end else begin
                error_r <= error_r;
            end
        end
    end

    assign bus.data      = data_r;
    assign bus.busy      = busy_r;
    assign bus.error     = error_r;
    assign bus.new_value = new_value_r;
endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames with a scoreboard of expected
// byte / framing-error events, checked by an independent monitor.
module tb_uart_rx;
    localparam int C    = 32;   // clocks per bit with the parameters below
    localparam int HALF = 16;

    logic clk;
    logic rst_n;

    uart_rx_if bus ();

    uart_rx #(
        .CLOCK_FREQUENCY(1600000),
        .BAUD_RATE      (50000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         n_checks;
    int         n_fails;
    logic [7:0] last_good;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},      {24'd0, bus.data},  32'h00);
        check({tag, "_busy"},      {31'd0, bus.busy},  32'h0);
        check({tag, "_error"},     {31'd0, bus.error}, 32'h0);
        check({tag, "_new_value"}, {31'd0, bus.new_value}, 32'h0);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    // Drives one frame starting at the current negedge; clear pulses at
    // clocks offset clear_at, reset is asserted at offset abort_at (<0: never).
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int clear_at, input int abort_at);
        logic [9:0] frame;
        exp_t       e;
        frame = {stop_bit, b, 1'b0};
        if (abort_at < 0) begin
            e.is_err = ~stop_bit;
            e.data   = stop_bit ? b : last_good;
            sb.push_back(e);
            if (stop_bit) last_good = b;
        end
        for (int cyc = 0; cyc < 10*C; cyc++) begin
            if (cyc == 3) check("busy_rise", {31'd0, bus.busy}, 32'h1);
            if (stop_bit && cyc == 10*C-1) check("busy_fall_in_stop", {31'd0, bus.busy}, 32'h0);
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                bus.clear = 1'b0;
                return;
            end
            bus.rx    = frame[cyc / C];
            bus.clear = (cyc == clear_at);
            @(negedge clk);
        end
        bus.clear = 1'b0;
        bus.rx    = 1'b1;
    endtask

    task automatic sb_event(input logic kind);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL sb_unexpected: event kind %0d with data 0x%0h, nothing expected", kind, bus.data);
        end else begin
            e = sb.pop_front();
            check("sb_kind", {31'd0, kind}, {31'd0, e.is_err});
            check("sb_data", {24'd0, bus.data}, {24'd0, e.data});
        end
    endtask

    // Monitor: every rising edge of new_value or error consumes one expected event.
    initial begin
        logic nv_p;
        logic er_p;
        nv_p = 1'b0;
        er_p = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.new_value && !nv_p) sb_event(1'b0);
            if (bus.error && !er_p)     sb_event(1'b1);
            nv_p = bus.new_value;
            er_p = bus.error;
        end
    end

    // Stimulus.
    initial begin
        n_checks  = 0;
        n_fails   = 0;
        last_good = 8'h00;
        rst_n     = 1'b0;
        bus.rx    = 1'b1;
        bus.clear = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal byte 0x55.
        send_frame(8'h55, 1'b1, -1, -1);
        check("nominal_data", {24'd0, bus.data}, 32'h55);
        check("nominal_nv",   {31'd0, bus.new_value}, 32'h1);
        check("nominal_err",  {31'd0, bus.error}, 32'h0);

        // Clear leaves data alone.
        pulse_clear();
        check("clear_nv",   {31'd0, bus.new_value}, 32'h0);
        check("clear_data", {24'd0, bus.data}, 32'h55);
        repeat (4) @(negedge clk);

        // Clear coincident with the set at mid stop bit: set wins.
        send_frame(8'h3C, 1'b1, 2 + HALF + 9*C, -1);
        repeat (2) @(negedge clk);
        check("coincide_nv",   {31'd0, bus.new_value}, 32'h1);
        check("coincide_data", {24'd0, bus.data}, 32'h3C);
        pulse_clear();
        check("coincide_cleared", {31'd0, bus.new_value}, 32'h0);
        repeat (4) @(negedge clk);

        // Framing error: 0xA3 with stop bit low.
        send_frame(8'hA3, 1'b0, -1, -1);
        repeat (HALF + 8) @(negedge clk);
        check("ferr_error", {31'd0, bus.error}, 32'h1);
        check("ferr_nv",    {31'd0, bus.new_value}, 32'h0);
        check("ferr_data",  {24'd0, bus.data}, 32'h3C);
        check("ferr_busy",  {31'd0, bus.busy}, 32'h0);
        pulse_clear();
        check("ferr_cleared", {31'd0, bus.error}, 32'h0);
        repeat (4) @(negedge clk);

        // False start: line low for a quarter bit.
        bus.rx = 1'b0;
        repeat (5) @(negedge clk);
        check("false_busy_high", {31'd0, bus.busy}, 32'h1);
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (12) @(negedge clk);
        check("false_busy_low", {31'd0, bus.busy}, 32'h0);
        check("false_nv",       {31'd0, bus.new_value}, 32'h0);
        check("false_err",      {31'd0, bus.error}, 32'h0);
        check("false_data",     {24'd0, bus.data}, 32'h3C);
        repeat (4) @(negedge clk);

        // Back-to-back frames with a single stop bit between them.
        send_frame(8'h0F, 1'b1, 9*C + HALF + 4, -1);
        send_frame(8'hF0, 1'b1, -1, -1);
        repeat (2) @(negedge clk);
        check("b2b_data", {24'd0, bus.data}, 32'hF0);
        check("b2b_nv",   {31'd0, bus.new_value}, 32'h1);

        // Reset in the middle of a data bit.
        send_frame(8'h96, 1'b1, -1, 4*C + 10);
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        rst_n  = 1'b1;
        last_good = 8'h00;
        repeat (5 + 2*C) @(negedge clk);
        check_reset_outputs("post_abort");

        check("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial (UART) receiver, 8N1 frame format: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Samples the incoming line at mid-bit using a clock-derived bit timer.
- Presents the received byte with a sticky "new value" flag and a sticky framing-error flag, both cleared by the consumer.
- Sits between the board RX pin and host-side logic that polls or reacts to new_value.

Parameters:
- CLOCK_FREQUENCY, 12000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate in bits/s.
- Derived, not overridable: CLKS_PER_BIT = CLOCK_FREQUENCY/BAUD_RATE (integer division; 1250 at defaults); HALF_BIT = CLKS_PER_BIT/2 (625).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  reset, asynchronous assert, active low.
- rx  input  1  serial line; idles high; asynchronous to clk.
- clear  input  1  synchronous; when high, clears new_value and error.
- data  output  8  last correctly framed byte.
- busy  output  1  high while a frame is being received.
- error  output  1  sticky framing-error flag.
- new_value  output  1  sticky flag: a new byte has been written to data.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, data=8'h00, busy=0, error=0, new_value=0, bit timer=0, bit index=0, synchronizer flops=1 (line idle).
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs, which adds 2 cycles of latency.
- Bit timer width: clog2(CLKS_PER_BIT).
- IDLE: busy=0. When rxs==0, go to START, load timer=0, set busy=1 in the same cycle.
- START: count HALF_BIT-1 cycles to reach the midpoint of the start bit.
  - If rxs==0 at the midpoint: go to DATA, timer=0, index=0.
  - If rxs==1 (glitch / false start): return to IDLE with busy=0. No error is raised.
- DATA: wait CLKS_PER_BIT cycles, then sample rxs into shift register bit[index], LSB first.
  - After index 7 is sampled, go to STOP.
- STOP: wait CLKS_PER_BIT cycles to reach mid stop bit, then sample.
  - rxs==1: data <= shift register, new_value <= 1.
  - rxs==0: error <= 1, data unchanged, new_value unchanged.
  - Either case: go to IDLE and drop busy the next cycle. Leaving at mid stop bit allows a back-to-back start edge to be caught.
- The receiver does not wait for rxs to be high again before rearming. A line stuck low after a framing error immediately begins a new frame attempt.
- clear: new_value<=0 and error<=0. If clear coincides with a set event, the set wins (flag ends at 1). clear has no effect on data, busy or state.
- Overrun: a new byte arriving while new_value==1 overwrites data; new_value stays 1. No separate overrun flag.
- No parity support. Frame timing tolerance is set by mid-bit sampling only.
- Reset mid-frame aborts immediately to IDLE with all outputs at reset values.

Test Plan:
- Reset: hold rst_n low 5 cycles with rx=1 -> data=0x00, busy=0, error=0, new_value=0.
- Nominal byte: after reset, drive start 0, then bits 1,0,1,0,1,0,1,0 (LSB first), then stop 1, each held 1250 clocks -> busy rises within 3 cycles of the start edge; at mid stop bit data=0x55, new_value=1, error=0; busy=0 before the stop bit ends.
- Clear: after the nominal byte, pulse clear for 1 cycle -> new_value=0, data stays 0x55. Also pulse clear in the same cycle new_value is set -> new_value remains 1.
- Framing error: send 0xA3 with stop bit held 0 -> error=1, new_value unchanged, data keeps previous value; clear -> error=0.
- False start: drive rx low for 300 clocks, then high -> busy pulses then returns to 0 by ~625 clocks; no flag set, data unchanged.
- Back-to-back and reset abort: send 0x0F then 0xF0 with a single-bit stop between -> data ends 0xF0, new_value=1. Then assert rst_n low mid-data-bit -> all outputs at reset values, busy=0.
